// File: rtl/vec_elem_sequencer.sv
// vec_elem_sequencer: expands a decoded vector instruction into per-element
// issue slots for the ID/EXE register, absorbing downstream stalls as bubbles.
// Optional build macro VSEQ_PERF_EN adds saturating element/bubble counters.
module vec_elem_sequencer #(
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned VL_W   = 6,
  parameter int unsigned MAX_VL = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_vector,
  input  logic [VL_W-1:0]  id_vl,
  input  logic             exe_stall,
  input  logic             flush,
  output logic [1:0]       next_state,
  output logic [CNT_W-1:0] cnt_i,
  output logic             elem_valid,
  output logic             stall_if,
`ifdef VSEQ_PERF_EN
  output logic [15:0]      perf_elems,
  output logic [15:0]      perf_bubbles,
`endif
  output logic             busy
);

  localparam logic [1:0] SLOT_SCALAR = 2'd0;
  localparam logic [1:0] SLOT_ELEM   = 2'd1;
  localparam logic [1:0] SLOT_LAST   = 2'd2;
  localparam logic [1:0] SLOT_BUBBLE = 2'd3;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           st, st_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] vl_m1, vl_m1_nx;
  logic [VL_W-1:0]  vl_e;

  // Clamp requested length to the hardware maximum
  always_comb begin
    vl_e = id_vl;
    if (id_vl > VL_W'(MAX_VL)) vl_e = VL_W'(MAX_VL);
  end

  // State, element counter and last-index registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= IDLE;
      cnt   <= '0;
      vl_m1 <= '0;
    end else begin
      st    <= st_nx;
      cnt   <= cnt_nx;
      vl_m1 <= vl_m1_nx;
    end
  end

  // Next-state and slot outputs; flush beats stall beats normal issue
  always_comb begin
    st_nx      = st;
    cnt_nx     = cnt;
    vl_m1_nx   = vl_m1;
    next_state = SLOT_SCALAR;
    cnt_i      = '0;
    elem_valid = 1'b0;
    stall_if   = 1'b0;
    if (flush) begin
      st_nx  = IDLE;
      cnt_nx = '0;
    end else if (exe_stall) begin
      next_state = SLOT_BUBBLE;
      cnt_i      = cnt;
      stall_if   = 1'b1;
    end else if (st == RUN) begin
      cnt_i      = cnt;
      elem_valid = 1'b1;
      if (cnt == vl_m1) begin
        next_state = SLOT_LAST;
        st_nx      = IDLE;
        cnt_nx     = '0;
      end else begin
        next_state = SLOT_ELEM;
        stall_if   = 1'b1;
        cnt_nx     = cnt + CNT_W'(1);
      end
    end else if (id_valid && id_is_vector && (vl_e != '0)) begin
      elem_valid = 1'b1;
      if (vl_e == VL_W'(1)) begin
        next_state = SLOT_LAST;
      end else begin
        next_state = SLOT_ELEM;
        stall_if   = 1'b1;
        st_nx      = RUN;
        cnt_nx     = CNT_W'(1);
        vl_m1_nx   = CNT_W'(vl_e - VL_W'(1));
      end
    end
  end

  assign busy = (st == RUN);

`ifdef VSEQ_PERF_EN
  // Saturating counters of issued elements and bubbles; flush does not clear them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_elems   <= '0;
      perf_bubbles <= '0;
    end else begin
      if (elem_valid && (perf_elems != 16'hFFFF)) perf_elems <= perf_elems + 16'd1;
      if ((next_state == SLOT_BUBBLE) && (perf_bubbles != 16'hFFFF))
        perf_bubbles <= perf_bubbles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// Directed testbench for vec_elem_sequencer.
module tb_vec_elem_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, id_valid, id_is_vector, exe_stall, flush;
  logic [5:0] id_vl;
  logic [1:0] next_state;
  logic [4:0] cnt_i;
  logic       elem_valid, stall_if, busy;
`ifdef VSEQ_PERF_EN
  logic [15:0] perf_elems, perf_bubbles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vec_elem_sequencer dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_vector(id_is_vector),
    .id_vl(id_vl), .exe_stall(exe_stall), .flush(flush),
    .next_state(next_state), .cnt_i(cnt_i), .elem_valid(elem_valid),
    .stall_if(stall_if),
`ifdef VSEQ_PERF_EN
    .perf_elems(perf_elems), .perf_bubbles(perf_bubbles),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply ID-side inputs and let combinational outputs settle
  task automatic drive(input logic v, input logic vec, input logic [5:0] vl,
                       input logic stl, input logic fl);
    id_valid = v; id_is_vector = vec; id_vl = vl; exe_stall = stl; flush = fl;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 6'd0, 0, 0);
    cyc(); cyc();
    n_checks++;
    if ({next_state, cnt_i, elem_valid, stall_if, busy} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ns=%0d cnt=%0d ev=%0b st=%0b busy=%0b, want all 0",
               next_state, cnt_i, elem_valid, stall_if, busy);
    end
    drive(0, 0, 6'd0, 1, 0);
    n_checks++;
    if (stall_if !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall_if: got %0b want 1", stall_if);
    end
    drive(0, 0, 6'd0, 0, 0);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_scalar();
    drive(1, 0, 6'd4, 0, 0);
    n_checks++;
    if ({next_state, cnt_i, elem_valid, stall_if, busy} !== 10'd0) begin
      n_fail++;
      $display("FAIL scalar: got ns=%0d cnt=%0d ev=%0b st=%0b busy=%0b, want all 0",
               next_state, cnt_i, elem_valid, stall_if, busy);
    end
    cyc();
    drive(0, 0, 6'd0, 0, 0);
  endtask

  task automatic test_vl4();
    logic [1:0] ens [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
    logic       est [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       ebz [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 6'd4, 0, 0);
      n_checks++;
      if (next_state !== ens[i] || cnt_i !== 5'(i) || stall_if !== est[i] ||
          elem_valid !== 1'b1 || busy !== ebz[i]) begin
        n_fail++;
        $display("FAIL vl4_slot%0d: got ns=%0d cnt=%0d st=%0b ev=%0b busy=%0b, want ns=%0d cnt=%0d st=%0b ev=1 busy=%0b",
                 i, next_state, cnt_i, stall_if, elem_valid, busy, ens[i], i, est[i], ebz[i]);
      end
      cyc();
    end
    drive(0, 0, 6'd0, 0, 0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL vl4_idle_after: busy got %0b want 0", busy);
    end
`ifdef VSEQ_PERF_EN
    n_checks++;
    if (perf_elems !== 16'd4 || perf_bubbles !== 16'd0) begin
      n_fail++;
      $display("FAIL perf_after_vl4: got elems=%0d bubbles=%0d want 4/0", perf_elems, perf_bubbles);
    end
`endif
  endtask

  task automatic test_stall_bubble();
    logic       stl [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] ens [4] = '{2'd1, 2'd3, 2'd1, 2'd2};
    logic [4:0] ecn [4] = '{5'd0, 5'd1, 5'd1, 5'd2};
    logic       eev [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 6'd3, stl[i], 0);
      n_checks++;
      if (next_state !== ens[i] || cnt_i !== ecn[i] || elem_valid !== eev[i]) begin
        n_fail++;
        $display("FAIL stall_slot%0d: got ns=%0d cnt=%0d ev=%0b, want ns=%0d cnt=%0d ev=%0b",
                 i, next_state, cnt_i, elem_valid, ens[i], ecn[i], eev[i]);
      end
      cyc();
    end
    drive(0, 0, 6'd0, 0, 0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_idle_after: busy got %0b want 0", busy);
    end
`ifdef VSEQ_PERF_EN
    n_checks++;
    if (perf_elems !== 16'd7 || perf_bubbles !== 16'd1) begin
      n_fail++;
      $display("FAIL perf_after_stall: got elems=%0d bubbles=%0d want 7/1", perf_elems, perf_bubbles);
    end
`endif
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 6'd8, 0, 0);
      cyc();
    end
    drive(1, 1, 6'd8, 0, 1);
    n_checks++;
    if (next_state !== 2'd0 || elem_valid !== 1'b0 || stall_if !== 1'b0 || cnt_i !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_slot: got ns=%0d ev=%0b st=%0b cnt=%0d, want 0/0/0/0",
               next_state, elem_valid, stall_if, cnt_i);
    end
    cyc();
    // A stall exposes the internal counter on cnt_i
    drive(0, 0, 6'd0, 1, 0);
    n_checks++;
    if (busy !== 1'b0 || cnt_i !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_after: got busy=%0b cnt=%0d want 0/0", busy, cnt_i);
    end
    drive(0, 0, 6'd0, 0, 0);
  endtask

  task automatic test_boundaries();
    drive(1, 1, 6'd0, 0, 0);
    n_checks++;
    if (next_state !== 2'd0 || elem_valid !== 1'b0 || stall_if !== 1'b0) begin
      n_fail++;
      $display("FAIL vl0: got ns=%0d ev=%0b st=%0b want 0/0/0", next_state, elem_valid, stall_if);
    end
    cyc();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL vl0_busy: got %0b want 0", busy);
    end
    drive(1, 1, 6'd1, 0, 0);
    n_checks++;
    if (next_state !== 2'd2 || cnt_i !== 5'd0 || stall_if !== 1'b0 || elem_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL vl1: got ns=%0d cnt=%0d st=%0b ev=%0b want 2/0/0/1",
               next_state, cnt_i, stall_if, elem_valid);
    end
    cyc();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL vl1_busy: got %0b want 0", busy);
    end
    for (int i = 0; i < 32; i++) begin
      drive(1, 1, 6'd40, 0, 0);
      n_checks++;
      if (cnt_i !== 5'(i) || next_state !== ((i == 31) ? 2'd2 : 2'd1) || elem_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL vl40_slot%0d: got ns=%0d cnt=%0d ev=%0b want ns=%0d cnt=%0d ev=1",
                 i, next_state, cnt_i, elem_valid, (i == 31) ? 2 : 1, i);
      end
      cyc();
    end
    drive(0, 0, 6'd0, 0, 0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL vl40_idle_after: busy got %0b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 6'd8, 0, 0);
      cyc();
    end
    drive(1, 1, 6'd8, 0, 0);
    n_checks++;
    if (cnt_i !== 5'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_pre: got cnt=%0d busy=%0b want 5/1", cnt_i, busy);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    drive(0, 0, 6'd0, 1, 0);
    n_checks++;
    if (busy !== 1'b0 || cnt_i !== 5'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%0b cnt=%0d want 0/0", busy, cnt_i);
    end
    drive(0, 0, 6'd0, 0, 0);
    cyc();
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_vl4();
    test_stall_bubble();
    test_flush();
    test_boundaries();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
